wb2core: RTL

WB2CORE -- requirements
Module: wb2core

---
 rtl/ibex_wb_pkg.sv | 6 +
 rtl/wb2core.sv | 76 +++++++
 2 files changed

// File: rtl/ibex_wb_pkg.sv
// ibex_wb_pkg: shared bridge FSM states and Wishbone address width
// Exports: wb_state_e (IDLE, ACTIVE, DRAIN), WB_ADR_W
package ibex_wb_pkg;
  localparam int WB_ADR_W = 28;
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} wb_state_e;
endpackage

// File: rtl/wb2core.sv
// wb2core: pipelined Wishbone slave to req/gnt/rvalid core device bridge
// Ports: clk, rst (async high); wb_cyc/stb/we/adr/sel/dat_i in, wb_dat_o/ack/err/stall out;
//        core_req/we/be/addr/wdata out, core_gnt/rvalid/rdata/err in
module wb2core
  import ibex_wb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_cyc,
  input  logic                wb_stb,
  input  logic                wb_we,
  input  logic [WB_ADR_W-1:0] wb_adr,
  input  logic [3:0]          wb_sel,
  input  logic [31:0]         wb_dat_i,
  output logic [31:0]         wb_dat_o,
  output logic                wb_ack,
  output logic                wb_err,
  output logic                wb_stall,
  output logic                core_req,
  input  logic                core_gnt,
  output logic                core_we,
  output logic [3:0]          core_be,
  output logic [31:0]         core_addr,
  output logic [31:0]         core_wdata,
  input  logic                core_rvalid,
  input  logic [31:0]         core_rdata,
  input  logic                core_err
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  wb_state_e state, state_n;
  logic req_valid, req_valid_n, grant, accept, rsp, live;
  logic [CW-1:0] outstanding, outstanding_n;
  logic [WB_ADR_W-1:0] req_adr;
  always_comb begin
    core_req = req_valid & (outstanding < CW'(MAX_OUTSTANDING));
    grant = core_req & core_gnt;
    wb_stall = (state != ACTIVE) | (req_valid & !grant);
    accept = wb_cyc & wb_stb & !wb_stall;
    // responses with nothing outstanding are strays (e.g. after reset) and are dropped
    rsp = core_rvalid & (outstanding != '0);
    live = (state == ACTIVE) & wb_cyc & rsp;
    wb_ack = live & !core_err;
    wb_err = live & core_err;
    wb_dat_o = core_rdata;
    req_valid_n = accept | (req_valid & !grant);
    outstanding_n = outstanding + CW'(grant) - CW'(rsp);
    state_n = state;
    case (state)
      IDLE:    state_n = wb_cyc ? ACTIVE : IDLE;
      ACTIVE:  state_n = wb_cyc ? ACTIVE : ((req_valid | outstanding != '0) ? DRAIN : IDLE);
      default: state_n = (!req_valid_n && outstanding_n == '0) ? IDLE : DRAIN;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      req_valid <= 1'b0;
      outstanding <= '0;
    end else begin
      state <= state_n;
      req_valid <= req_valid_n;
      outstanding <= outstanding_n;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      core_we <= wb_we;
      core_be <= wb_sel;
      req_adr <= wb_adr;
      core_wdata <= wb_dat_i;
    end
  end
  assign core_addr = {2'b00, req_adr, 2'b00};
endmodule
